// File: rtl/injector_pulse_gen.sv
`default_nettype none
// ============================================================================
//  Module      : injector_pulse_gen
//  Description : Per-cylinder injector drive with programmable open time,
//                enforced dead time, and truncated/missed reporting.
//  Revision    : 1.0 - initial release
// ============================================================================

`ifndef CFG_CYLINDERS
`define CFG_CYLINDERS 4
`endif

module injector_pulse_gen #(
    parameter int CYLINDERS = `CFG_CYLINDERS,
    parameter int PW_WIDTH  = 20,
    parameter int DEAD_TIME = 250
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 on,
    input  logic [CYLINDERS-1:0] allow_injection,
    input  logic [CYLINDERS-1:0] fic_on,
    input  logic [PW_WIDTH-1:0]  pulse_width,
    output logic [CYLINDERS-1:0] injector,
    output logic [CYLINDERS-1:0] busy,
    output logic [CYLINDERS-1:0] truncated,
    output logic [CYLINDERS-1:0] missed
);

    localparam int                 c_REC_W    = $clog2(DEAD_TIME + 1);
    localparam logic [c_REC_W-1:0] c_REC_LOAD = c_REC_W'(DEAD_TIME - 1);

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_OPEN    = 2'd1;
    localparam logic [1:0] c_ST_RECOVER = 2'd2;

    // Resetting to ones suppresses a window that is already open at reset release.
    logic [CYLINDERS-1:0] r_allow_prev;
    logic [CYLINDERS-1:0] w_start_req;
    logic                 w_pw_nonzero;
    logic [PW_WIDTH-1:0]  w_pw_load;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_allow_prev <= '1;
        end else begin
            r_allow_prev <= allow_injection;
        end
    end

    assign w_start_req  = allow_injection & ~r_allow_prev;
    assign w_pw_nonzero = |pulse_width;
    assign w_pw_load    = pulse_width - PW_WIDTH'(1);

    for (genvar gi = 0; gi < CYLINDERS; gi++) begin : g_channel
        logic [1:0]          r_state;
        logic [1:0]          w_state_nxt;
        logic [PW_WIDTH-1:0] r_pw_cnt;
        logic [PW_WIDTH-1:0] w_pw_cnt_nxt;
        logic [c_REC_W-1:0]  r_rec_cnt;
        logic [c_REC_W-1:0]  w_rec_cnt_nxt;
        logic                r_inj;
        logic                w_inj_nxt;
        logic                r_trunc;
        logic                w_trunc_nxt;
        logic                r_miss;
        logic                w_miss_nxt;
        logic                w_can_start;

        always_comb begin
            w_state_nxt   = r_state;
            w_pw_cnt_nxt  = r_pw_cnt;
            w_rec_cnt_nxt = r_rec_cnt;
            w_inj_nxt     = r_inj;
            w_trunc_nxt   = 1'b0;
            w_miss_nxt    = 1'b0;
            w_can_start   = 1'b0;

            if (!on) begin
                w_state_nxt   = c_ST_IDLE;
                w_inj_nxt     = 1'b0;
                w_pw_cnt_nxt  = '0;
                w_rec_cnt_nxt = '0;
            end else begin
                case (r_state)
                    c_ST_IDLE: begin
                        w_can_start = 1'b1;
                    end
                    c_ST_OPEN: begin
                        // Natural completion takes priority over a same-cycle abort.
                        if (r_pw_cnt == '0) begin
                            w_inj_nxt     = 1'b0;
                            w_rec_cnt_nxt = c_REC_LOAD;
                            w_state_nxt   = c_ST_RECOVER;
                        end else if (!allow_injection[gi] || !fic_on[gi]) begin
                            w_inj_nxt     = 1'b0;
                            w_trunc_nxt   = 1'b1;
                            w_rec_cnt_nxt = c_REC_LOAD;
                            w_state_nxt   = c_ST_RECOVER;
                        end else begin
                            w_pw_cnt_nxt = r_pw_cnt - PW_WIDTH'(1);
                        end
                    end
                    c_ST_RECOVER: begin
                        // Last dead-time cycle behaves like IDLE so a restart lands exactly on time.
                        if (r_rec_cnt == '0) begin
                            w_state_nxt = c_ST_IDLE;
                            w_can_start = 1'b1;
                        end else begin
                            w_rec_cnt_nxt = r_rec_cnt - c_REC_W'(1);
                            w_miss_nxt    = w_start_req[gi];
                        end
                    end
                    default: begin
                        w_state_nxt = c_ST_IDLE;
                        w_inj_nxt   = 1'b0;
                    end
                endcase

                if (w_can_start && w_start_req[gi] && fic_on[gi]) begin
                    if (w_pw_nonzero) begin
                        w_state_nxt  = c_ST_OPEN;
                        w_inj_nxt    = 1'b1;
                        w_pw_cnt_nxt = w_pw_load;
                    end else begin
                        w_miss_nxt = 1'b1;
                    end
                end
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_state   <= c_ST_IDLE;
                r_pw_cnt  <= '0;
                r_rec_cnt <= '0;
                r_inj     <= 1'b0;
                r_trunc   <= 1'b0;
                r_miss    <= 1'b0;
            end else begin
                r_state   <= w_state_nxt;
                r_pw_cnt  <= w_pw_cnt_nxt;
                r_rec_cnt <= w_rec_cnt_nxt;
                r_inj     <= w_inj_nxt;
                r_trunc   <= w_trunc_nxt;
                r_miss    <= w_miss_nxt;
            end
        end

        assign injector[gi]  = r_inj;
        assign busy[gi]      = (r_state != c_ST_IDLE);
        assign truncated[gi] = r_trunc;
        assign missed[gi]    = r_miss;
    end

endmodule

`default_nettype wire

// File: tb/tb_injector_pulse_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_injector_pulse_gen
//  Description : Scoreboard bench for injector_pulse_gen (4 channels).
//  Revision    : 1.0 - initial release
// ============================================================================

module tb_injector_pulse_gen;

    localparam int c_CYL  = 4;
    localparam int c_PW_W = 20;
    localparam int c_DEAD = 250;

    localparam int c_K_TRUNC = 0;
    localparam int c_K_PULSE = 1;
    localparam int c_K_MISS  = 2;
    localparam int c_K_BUSY  = 3;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              on;
    logic [c_CYL-1:0]  allow_injection;
    logic [c_CYL-1:0]  fic_on;
    logic [c_PW_W-1:0] pulse_width;
    logic [c_CYL-1:0]  injector;
    logic [c_CYL-1:0]  busy;
    logic [c_CYL-1:0]  truncated;
    logic [c_CYL-1:0]  missed;

    injector_pulse_gen #(
        .CYLINDERS (c_CYL),
        .PW_WIDTH  (c_PW_W),
        .DEAD_TIME (c_DEAD)
    ) u_dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .on              (on),
        .allow_injection (allow_injection),
        .fic_on          (fic_on),
        .pulse_width     (pulse_width),
        .injector        (injector),
        .busy            (busy),
        .truncated       (truncated),
        .missed          (missed)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ch;
        int kind;
        int val;
    } ev_t;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_errors = 0;

    function automatic string kind_name(int k);
        case (k)
            c_K_TRUNC: return "truncated";
            c_K_PULSE: return "pulse_len";
            c_K_MISS:  return "missed";
            default:   return "busy_len";
        endcase
    endfunction

    task automatic expect_ev(int ch, int kind, int val);
        ev_t e;
        e.ch   = ch;
        e.kind = kind;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic observe(int ch, int kind, int val);
        ev_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL unexpected_event: actual ch%0d %s %0d, required no event",
                     ch, kind_name(kind), val);
        end else begin
            e = exp_q.pop_front();
            if (e.ch != ch || e.kind != kind || e.val != val) begin
                n_errors++;
                $display("FAIL event: actual ch%0d %s %0d, required ch%0d %s %0d",
                         ch, kind_name(kind), val, e.ch, kind_name(e.kind), e.val);
            end
        end
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    task automatic drain(string name);
        check({name, "_pending_events"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: turns output waveforms into events and scores them in a fixed per-cycle order.
    logic [c_CYL-1:0] prev_inj  = '0;
    logic [c_CYL-1:0] prev_busy = '0;
    int               inj_len  [c_CYL];
    int               busy_len [c_CYL];

    initial begin
        for (int c = 0; c < c_CYL; c++) begin
            inj_len[c]  = 0;
            busy_len[c] = 0;
        end
        forever begin
            @(negedge clk);
            for (int c = 0; c < c_CYL; c++) begin
                if (truncated[c]) observe(c, c_K_TRUNC, 0);
                if (prev_inj[c] && !injector[c]) observe(c, c_K_PULSE, inj_len[c]);
                if (missed[c]) observe(c, c_K_MISS, 0);
                if (prev_busy[c] && !busy[c]) observe(c, c_K_BUSY, busy_len[c]);
                inj_len[c]   = injector[c] ? (prev_inj[c] ? inj_len[c] + 1 : 1) : 0;
                busy_len[c]  = busy[c] ? (prev_busy[c] ? busy_len[c] + 1 : 1) : 0;
                prev_inj[c]  = injector[c];
                prev_busy[c] = busy[c];
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n         = 1'b0;
        on              = 1'b0;
        allow_injection = '0;
        fic_on          = '0;
        pulse_width     = '0;
        #23;
        check("reset_injector",  injector,  0);
        check("reset_busy",      busy,      0);
        check("reset_truncated", truncated, 0);
        check("reset_missed",    missed,    0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        tick(3);
        on     = 1'b1;
        fic_on = 4'hF;

        // Basic pulse on channel 0
        pulse_width        = 1000;
        allow_injection[0] = 1'b1;
        expect_ev(0, c_K_PULSE, 1000);
        expect_ev(0, c_K_BUSY,  1250);
        tick(5000);
        allow_injection[0] = 1'b0;
        tick(5);
        drain("basic");

        // Truncation after 400 cycles
        allow_injection[0] = 1'b1;
        expect_ev(0, c_K_TRUNC, 0);
        expect_ev(0, c_K_PULSE, 400);
        expect_ev(0, c_K_BUSY,  650);
        tick(400);
        allow_injection[0] = 1'b0;
        tick(300);
        drain("truncation");

        // Second request during recovery is missed
        pulse_width        = 100;
        allow_injection[1] = 1'b1;
        expect_ev(1, c_K_PULSE, 100);
        expect_ev(1, c_K_MISS,  0);
        expect_ev(1, c_K_BUSY,  350);
        tick(140);
        allow_injection[1] = 1'b0;
        tick(10);
        allow_injection[1] = 1'b1;
        tick(300);
        allow_injection[1] = 1'b0;
        tick(5);
        drain("missed_recover");

        // Zero pulse width is rejected
        pulse_width        = 0;
        allow_injection[2] = 1'b1;
        expect_ev(2, c_K_MISS, 0);
        tick(5);
        allow_injection[2] = 1'b0;
        tick(2);
        drain("zero_width");

        // fic_on low gates silently
        fic_on             = 4'b1011;
        pulse_width        = 50;
        allow_injection[2] = 1'b1;
        tick(60);
        check("gated_injector", injector, 0);
        allow_injection[2] = 1'b0;
        fic_on             = 4'hF;
        tick(2);
        drain("gated");

        // Abort on the completion cycle: completion wins
        pulse_width        = 20;
        allow_injection[2] = 1'b1;
        expect_ev(2, c_K_PULSE, 20);
        expect_ev(2, c_K_BUSY,  270);
        tick(20);
        allow_injection[2] = 1'b0;
        tick(280);
        drain("abort_at_completion");

        // Earliest restart at pulse_width + DEAD_TIME
        pulse_width        = 10;
        allow_injection[1] = 1'b1;
        expect_ev(1, c_K_PULSE, 10);
        expect_ev(1, c_K_PULSE, 10);
        expect_ev(1, c_K_BUSY,  520);
        tick(15);
        allow_injection[1] = 1'b0;
        tick(245);
        allow_injection[1] = 1'b1;
        tick(280);
        allow_injection[1] = 1'b0;
        tick(5);
        drain("back_to_back");

        // Concurrent channels 0 and 3 with mid-pulse width change
        pulse_width     = 500;
        allow_injection = 4'b1001;
        expect_ev(0, c_K_PULSE, 500);
        expect_ev(3, c_K_PULSE, 500);
        expect_ev(0, c_K_BUSY,  750);
        expect_ev(3, c_K_BUSY,  750);
        tick(100);
        pulse_width = 10;
        tick(700);
        allow_injection = '0;
        tick(5);
        drain("concurrent");

        // Global off mid-OPEN on all channels
        pulse_width     = 1000;
        allow_injection = 4'hF;
        for (int c = 0; c < c_CYL; c++) begin
            expect_ev(c, c_K_PULSE, 300);
            expect_ev(c, c_K_BUSY,  300);
        end
        tick(300);
        on = 1'b0;
        tick(1);
        check("off_injector",  injector,  0);
        check("off_truncated", truncated, 0);
        tick(5);
        on = 1'b1;
        tick(5);
        allow_injection = '0;
        tick(5);
        drain("global_off");

        // Asynchronous reset mid-pulse, release with window high
        allow_injection[0] = 1'b1;
        expect_ev(0, c_K_PULSE, 99);
        expect_ev(0, c_K_BUSY,  99);
        tick(100);
        #2 reset_n = 1'b0;
        #1;
        check("async_reset_injector", injector, 0);
        check("async_reset_busy",     busy,     0);
        tick(3);
        reset_n = 1'b1;
        tick(50);
        check("release_high_injector", injector, 0);
        allow_injection[0] = 1'b0;
        tick(3);
        drain("async_reset");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/injector_pulse_gen.md
# injector_pulse_gen

Per-cylinder fuel-injector drive generator downstream of `stroke_transition`. It consumes the `allow_injection` and `fic_on` vectors that `stroke_transition` produces. For each cylinder it emits one injector-open pulse per injection window, with a programmable width in clock cycles and an enforced recovery (dead) time. Its outputs drive the injector driver pins directly and report truncated or missed injections to the fuel-control logic.

## Interface
- `CYLINDERS`, default `` `CFG_CYLINDERS ``: number of independent injector channels.
- `PW_WIDTH`, default 20: width of the pulse-width operand, in clock cycles (max ≈ 8.4 ms at 125 MHz).
- `DEAD_TIME`, default 250: forced low cycles after every pulse (2 µs at 125 MHz). Must be ≥ 1.

Ports:
- `clk` in 1: system clock, 125 MHz, rising edge.
- `reset_n` in 1: reset, asynchronous assert, active-low.
- `on` in 1: global enable, same signal as fed to `stroke_transition`.
- `allow_injection` in `CYLINDERS`: per-cylinder injection window from `stroke_transition`.
- `fic_on` in `CYLINDERS`: per-cylinder fuel-injection-controller enable from `stroke_transition`.
- `pulse_width` in `PW_WIDTH`: requested open time in cycles, shared by all channels, sampled at pulse start.
- `injector` out `CYLINDERS`: injector drive, 1 = open. Registered.
- `busy` out `CYLINDERS`: channel is in OPEN or RECOVER.
- `truncated` out `CYLINDERS`: one-cycle pulse when an OPEN pulse is cut short.
- `missed` out `CYLINDERS`: one-cycle pulse when a start request is rejected.

## Operation
- Each channel has an independent FSM with states IDLE, OPEN and RECOVER, plus a `PW_WIDTH`-bit down-counter and a `$clog2(DEAD_TIME+1)`-bit recovery counter.
- **Start request:** the channel's `allow_injection` bit is 1 and its registered previous value is 0 (rising edge).
- The previous-value register resets to all ones. A window that is already high when reset is released therefore never fires.
- **IDLE → OPEN:** start request AND `on` AND `fic_on[i]` AND `pulse_width != 0`.
  - `injector[i]` is set and the counter is loaded with `pulse_width - 1`.
- **IDLE, no transition:**
  - A start request with `on`=1 and `fic_on[i]`=1 but `pulse_width == 0` pulses `missed[i]` and stays in IDLE.
  - A start request with `on`=0 or `fic_on[i]`=0 does nothing and raises no flag.
- **OPEN:** the counter decrements each cycle.
  - When counter == 0: clear `injector[i]`, load the recovery counter with `DEAD_TIME - 1`, go to RECOVER.
- **OPEN abort:** `allow_injection[i]` falls or `fic_on[i]` falls before completion.
  - Clear `injector[i]`, pulse `truncated[i]`, go to RECOVER.
  - If the abort and natural completion land on the same cycle, completion wins: no `truncated`.
- **RECOVER:** the recovery counter decrements. At 0, go to IDLE. A start request in RECOVER pulses `missed[i]` and is not queued.
- **`on` = 0:** all channels go to IDLE on the next edge. `injector`, `truncated` and `missed` go to 0 and no flags are raised. Recovery is skipped.
- **Pulse-width changes:** `pulse_width` changes during OPEN have no effect on the pulse in flight.
- **Multiple channels:** any number of channels may be OPEN simultaneously. They share no state besides the inputs.

## Timing
- **Reset values:** all outputs 0, all FSMs in IDLE, previous-value register all ones, counters 0.
- **Start latency:** when the start request is sampled at edge N, `injector[i]` = 1 from edge N to edge N+`pulse_width`. That is exactly `pulse_width` cycles high.
- **Recovery:** `injector[i]` = 0 for exactly `DEAD_TIME` cycles in RECOVER. The earliest next start request is accepted `pulse_width + DEAD_TIME` cycles after the previous one.
- **Abort timing:** the abort condition sampled at edge M gives `injector[i]` = 0 and `truncated[i]` = 1 after edge M. `truncated` lasts one cycle.
- **Missed timing:** `missed[i]` is asserted in the cycle following the rejected start request, for one cycle.
- **`busy[i]`:** `busy[i]` = 1 whenever the state is OPEN or RECOVER, registered with the state.
- **Asynchronous reset mid-pulse:** `injector` drops immediately, without waiting for a clock edge.

## Test plan
- **Basic pulse:** `pulse_width`=1000, `fic_on[0]`=1, `on`=1, raise `allow_injection[0]` for 5000 cycles.
  - `injector[0]` high exactly 1000 cycles starting at the sampling edge.
  - `busy[0]` high for 1250 cycles.
  - No flags.
- **Truncation:** `pulse_width`=1000, drop `allow_injection[0]` after 400 cycles.
  - `injector[0]` high 400 cycles.
  - `truncated[0]` pulses once.
  - RECOVER lasts 250 cycles.
- **Missed in recovery:** `pulse_width`=100, toggle `allow_injection[1]` back up 150 cycles after the first rise.
  - Second request gives `missed[1]` for one cycle.
  - No second pulse.
- **Zero width and gating:**
  - `pulse_width`=0 with a start request gives `missed` and no pulse.
  - `fic_on`=0 with a start request gives no pulse and no flag.
- **Global off and reset:**
  - Drop `on` mid-OPEN on all 4 channels: all `injector` bits are 0 after the next edge, no `truncated`.
  - Assert `reset_n`=0 mid-pulse: `injector` is 0 without waiting for a clock edge.
  - Release reset with `allow_injection` high: no pulse.
- **Concurrent channels:** channel 0 and channel 3 start on the same cycle with `pulse_width`=500.
  - Identical, independent 500-cycle pulses.
  - A mid-pulse `pulse_width` change to 10 does not alter them.
